// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, parity modes and word field offsets for uart_rx_cfg
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WRITE,
        S_BRKWAIT
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Status flags sit directly above the data field: {brk, perr, ferr, data}
    function automatic int FERR_BIT(input int data_w);
        return data_w;
    endfunction

    function automatic int PERR_BIT(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int BRK_BIT(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_sync_vote.sv
// rtl/uart_rx_cfg_sync_vote.sv - two-flop synchroniser and 3-sample majority vote
module uart_rx_sync_vote (
    input  logic rx_sclk_i,
    input  logic rx_srst_i,
    input  logic rx_data_i,
    output logic vote,
    output logic primed
);

    logic [1:0] sync_q;
    logic [2:0] vote_sr;
    logic [3:0] settle_sr;

    always_ff @(posedge rx_sclk_i) begin
        if (rx_srst_i) begin
            sync_q    <= 2'b11;
            vote_sr   <= 3'b111;
            settle_sr <= 4'b0000;
        end else begin
            sync_q    <= {sync_q[0], rx_data_i};
            vote_sr   <= {vote_sr[1:0], sync_q[1]};
            settle_sr <= {settle_sr[2:0], 1'b1};
        end
    end

    assign vote = (vote_sr[0] & vote_sr[1]) | (vote_sr[1] & vote_sr[2]) | (vote_sr[0] & vote_sr[2]);

    // Until the pipeline has flushed, vote still shows the reset ones, not the pin
    assign primed = settle_sr[3];

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised oversampling UART receiver feeding a FIFO write port
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              rx_sclk_i,
    input  logic              rx_srst_i,
    input  logic              rx_data_i,
    input  logic              wfull_i,
    output logic [DATA_W+2:0] wdata_o,
    output logic              winc_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam int FERR_B = FERR_BIT(DATA_W);
    localparam int PERR_B = PERR_BIT(DATA_W);
    localparam int BRK_B  = BRK_BIT(DATA_W);

    rx_state_t         state;
    logic              armed;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] data_sr;
    logic              stop_idx;
    logic              perr;
    logic              ferr;
    logic              par_zero;
    logic              stop0_zero;
    logic              vote;
    logic              primed;
    logic              brk;
    logic [DATA_W+2:0] word;

    uart_rx_sync_vote u_sync_vote (
        .rx_sclk_i (rx_sclk_i),
        .rx_srst_i (rx_srst_i),
        .rx_data_i (rx_data_i),
        .vote      (vote),
        .primed    (primed)
    );

    assign brk = (data_sr == '0) && (PARITY == PAR_NONE || par_zero) && stop0_zero;

    always_comb begin
        word                 = '0;
        word[DATA_W-1:0]     = data_sr;
        word[FERR_B]         = ferr | brk;
        word[PERR_B]         = perr;
        word[BRK_B]          = brk;
    end

    always_ff @(posedge rx_sclk_i) begin
        if (rx_srst_i) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            data_sr    <= '0;
            stop_idx   <= 1'b0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            par_zero   <= 1'b0;
            stop0_zero <= 1'b0;
            wdata_o    <= '0;
            winc_o     <= 1'b0;
            overrun_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            winc_o    <= 1'b0;
            overrun_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (vote) begin
                        armed <= armed | primed;
                    end else if (armed) begin
                        state  <= S_START;
                        cnt    <= '0;
                        perr   <= 1'b0;
                        ferr   <= 1'b0;
                        busy_o <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (vote) begin
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        data_sr <= {vote, data_sr[DATA_W-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state    <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        perr     <= vote ^ (^data_sr) ^ (PARITY == PAR_ODD);
                        par_zero <= ~vote;
                        state    <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!vote) ferr <= 1'b1;
                        if (!stop_idx) stop0_zero <= ~vote;
                        if (stop_idx == 1'(STOP_BITS - 1)) state <= S_WRITE;
                        else stop_idx <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    // The word is presented even when dropped, so overrun can be inspected
                    wdata_o   <= word;
                    winc_o    <= ~wfull_i;
                    overrun_o <= wfull_i;
                    if (brk) begin
                        state <= S_BRKWAIT;
                    end else begin
                        state  <= S_IDLE;
                        armed  <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                S_BRKWAIT: begin
                    if (vote) begin
                        state  <= S_IDLE;
                        armed  <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg (8N1 and 8E2 instances)
module tb_uart_rx_cfg;

    localparam int OS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst;
    logic        line0, line1, wfull0, wfull1;
    logic [10:0] wdata0, wdata1;
    logic        winc0, winc1, ovr0, ovr1, busy0, busy1;

    uart_rx_cfg dut0 (
        .rx_sclk_i (clk), .rx_srst_i (srst), .rx_data_i (line0), .wfull_i (wfull0),
        .wdata_o (wdata0), .winc_o (winc0), .overrun_o (ovr0), .busy_o (busy0)
    );

    uart_rx_cfg #(.DATA_W(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(2)) dut1 (
        .rx_sclk_i (clk), .rx_srst_i (srst), .rx_data_i (line1), .wfull_i (wfull1),
        .wdata_o (wdata1), .winc_o (winc1), .overrun_o (ovr1), .busy_o (busy1)
    );

    typedef struct {
        int          t;
        logic [10:0] w;
    } wr_t;

    typedef struct {
        int          which;
        logic [7:0]  d;
        logic        pb;
        logic [1:0]  st;
        logic [10:0] exp;
    } vec_t;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   ovr_cnt0 = 0;
    int   busy_cnt0 = 0;
    int   both_hi = 0;
    wr_t  q0[$];
    wr_t  q1[$];
    wr_t  e0, e1;
    vec_t tbl[12];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (winc0) begin e0.t = cyc; e0.w = wdata0; q0.push_back(e0); end
        if (winc1) begin e1.t = cyc; e1.w = wdata1; q1.push_back(e1); end
        if (ovr0) ovr_cnt0++;
        if (busy0) busy_cnt0++;
        if ((winc0 && ovr0) || (winc1 && ovr1)) both_hi++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Expected word from the frame contents alone
    function automatic logic [10:0] model(input int which, input logic [7:0] d,
                                          input logic pb, input logic [1:0] st);
        int par_mode = (which == 1) ? 1 : 0;
        int nstop    = (which == 1) ? 2 : 1;
        bit perr = 1'b0;
        bit ferr = 1'b0;
        bit brk;
        if (par_mode != 0) perr = ((($countones(d) + int'(pb)) % 2) != (par_mode == 2 ? 1 : 0));
        for (int k = 0; k < nstop; k++) if (st[k] == 1'b0) ferr = 1'b1;
        brk = (d == 8'h00) && (par_mode == 0 || pb == 1'b0) && (st[0] == 1'b0);
        if (brk) ferr = 1'b1;
        return {brk, perr, ferr, d};
    endfunction

    task automatic set_line(input int which, input logic v);
        if (which == 1) line1 = v;
        else line0 = v;
    endtask

    task automatic drive_frame(input int which, input logic [7:0] d, input logic pb,
                               input logic [1:0] st, output int t0);
        logic [15:0] v;
        int n;
        v = '1;
        v[0] = 1'b0;
        v[8:1] = d;
        n = 9;
        if (which == 1) begin v[n] = pb; n++; end
        v[n] = st[0];
        n++;
        if (which == 1) begin v[n] = st[1]; n++; end
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            set_line(which, v[i]);
            tick(OS);
        end
        set_line(which, 1'b1);
    endtask

    task automatic check_pop(input int which, input logic [10:0] exp, input int t0, input string name);
        wr_t e;
        int  nb = (which == 1) ? 12 : 10;
        int  lo = (2 * nb - 1) * OS / 2 + 2;
        int  sz = (which == 1) ? q1.size() : q0.size();
        if (sz == 0) begin
            checks++;
            fails++;
            $display("FAIL %s: no write seen, expected word %0h", name, exp);
            return;
        end
        e = (which == 1) ? q1.pop_front() : q0.pop_front();
        check({name, "_word"}, 32'(e.w), 32'(exp));
        if (t0 >= 0) check_range({name, "_lat"}, e.t - t0, lo, lo + 8);
    endtask

    task automatic check_empty(input int which, input string name);
        int sz = (which == 1) ? q1.size() : q0.size();
        check({name, "_nwrites"}, 32'(sz), 32'd0);
        if (which == 1) q1.delete();
        else q0.delete();
    endtask

    initial begin
        int t0, t1, b0, o0, which;
        logic [7:0] d;
        logic pb;
        logic [1:0] st;

        tbl[0]  = '{0, 8'hA5, 1'b0, 2'b11, 11'h0A5};
        tbl[1]  = '{0, 8'h55, 1'b0, 2'b10, 11'h155};
        tbl[2]  = '{0, 8'h12, 1'b0, 2'b11, 11'h012};
        tbl[3]  = '{0, 8'h00, 1'b0, 2'b11, 11'h000};
        tbl[4]  = '{0, 8'hFF, 1'b0, 2'b11, 11'h0FF};
        tbl[5]  = '{1, 8'h03, 1'b1, 2'b11, 11'h203};
        tbl[6]  = '{1, 8'h03, 1'b0, 2'b11, 11'h003};
        tbl[7]  = '{1, 8'h80, 1'b1, 2'b11, 11'h080};
        tbl[8]  = '{1, 8'h80, 1'b0, 2'b11, 11'h280};
        tbl[9]  = '{1, 8'h5A, 1'b0, 2'b01, 11'h15A};
        tbl[10] = '{1, 8'h00, 1'b0, 2'b10, 11'h500};
        tbl[11] = '{1, 8'h7E, 1'b1, 2'b11, 11'h27E};

        srst = 1'b1; line0 = 1'b0; line1 = 1'b1; wfull0 = 1'b0; wfull1 = 1'b0;
        tick(4);
        check("rst_wdata0", 32'(wdata0), 32'd0);
        check("rst_winc0", 32'(winc0), 32'd0);
        check("rst_ovr0", 32'(ovr0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_wdata1", 32'(wdata1), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);

        // Line held low out of reset must not start a frame
        b0 = busy_cnt0;
        srst = 1'b0;
        tick(40);
        line0 = 1'b1;
        tick(3 * OS);
        check("low_out_of_reset_busy", 32'(busy_cnt0 - b0), 32'd0);
        check_empty(0, "low_out_of_reset");

        for (int i = 0; i < 12; i++) begin
            drive_frame(tbl[i].which, tbl[i].d, tbl[i].pb, tbl[i].st, t0);
            tick(3 * OS);
            check_pop(tbl[i].which, tbl[i].exp, t0, $sformatf("tbl%0d", i));
            check_empty(tbl[i].which, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            which = i % 2;
            d  = 8'($urandom);
            pb = 1'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            drive_frame(which, d, pb, st, t0);
            tick(3 * OS);
            check_pop(which, model(which, d, pb, st), t0, $sformatf("rnd%0d", i));
            check_empty(which, $sformatf("rnd%0d", i));
        end

        // Back-to-back frames with no idle bit between them
        drive_frame(0, 8'h3A, 1'b0, 2'b11, t0);
        drive_frame(0, 8'hC5, 1'b0, 2'b11, t1);
        tick(3 * OS);
        check_pop(0, 11'h03A, t0, "b2b_a");
        check_pop(0, 11'h0C5, t1, "b2b_b");
        check_empty(0, "b2b");

        // Long break: one word only, busy held until the line rises
        line0 = 1'b0;
        tick(12 * OS);
        check("brk_busy_low", 32'(busy0), 32'd1);
        check("brk_nwrites_low", 32'(q0.size()), 32'd1);
        line0 = 1'b1;
        tick(3 * OS);
        check_pop(0, 11'h500, -1, "brk");
        check_empty(0, "brk");
        check("brk_busy_after", 32'(busy0), 32'd0);

        // Short low glitch is rejected as a false start
        b0 = busy_cnt0;
        line0 = 1'b0;
        tick(5);
        line0 = 1'b1;
        tick(3 * OS);
        check_empty(0, "glitch");
        check_range("glitch_busy_cycles", busy_cnt0 - b0, 6, 12);
        check("glitch_busy_end", 32'(busy0), 32'd0);

        // Full FIFO drops the word with a single overrun pulse
        wfull0 = 1'b1;
        o0 = ovr_cnt0;
        drive_frame(0, 8'h3C, 1'b0, 2'b11, t0);
        tick(2 * OS);
        check_empty(0, "overrun");
        check("overrun_pulses", 32'(ovr_cnt0 - o0), 32'd1);
        check("overrun_wdata", 32'(wdata0), 32'h03C);
        wfull0 = 1'b0;

        // Reset in the middle of a frame abandons it
        line0 = 1'b0;
        tick(OS);
        line0 = 1'b1;
        tick(2 * OS);
        check("midframe_busy", 32'(busy0), 32'd1);
        srst = 1'b1;
        tick(2);
        srst = 1'b0;
        tick(1);
        check("midrst_wdata", 32'(wdata0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_winc", 32'(winc0), 32'd0);
        check("midrst_ovr", 32'(ovr0), 32'd0);
        tick(12 * OS);
        check_empty(0, "midrst");

        check("winc_ovr_exclusive", 32'(both_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
